// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types for the ALU flag unit:
//   alu_op_t     - 4-bit ALU operation code
//   alu_state_t  - control FSM state encoding (exported for debug observation)
//   alu_out_t    - bundle produced by the binary execute stage
//   is_bcd_op()  - true for the ops that take a decimal correction when D=1
// -----------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [3:0] {
    OP_ADC = 4'h0,
    OP_SBC = 4'h1,
    OP_CMP = 4'h2,
    OP_AND = 4'h3,
    OP_ORA = 4'h4,
    OP_EOR = 4'h5,
    OP_ASL = 4'h6,
    OP_LSR = 4'h7,
    OP_ROL = 4'h8,
    OP_ROR = 4'h9,
    OP_INC = 4'hA,
    OP_DEC = 4'hB
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DADJ = 2'd2,
    ST_REQ  = 2'd3
  } alu_state_t;

  typedef struct packed {
    logic [7:0] result;
    logic       n;
    logic       v;
    logic       z;
    logic       c;
    logic       hc;   // carry out of bit 3, only meaningful for ADC/SBC
  } alu_out_t;

  function automatic logic is_bcd_op(input alu_op_t op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/bcd_adjust.sv
// -----------------------------------------------------------------------------
// bcd_adjust
// Combinational decimal correction applied after a binary ADC/SBC.
// Ports:
//   bin_sum    (in, 8)  binary result of A + B + C or A + ~B + C
//   half_carry (in, 1)  carry out of bit 3 of the binary operation
//   carry_in   (in, 1)  carry out of bit 7 of the binary operation
//   is_sub     (in, 1)  1 for SBC, 0 for ADC
//   adj_out    (out, 8) decimal-corrected byte
//   carry_out  (out, 1) decimal carry (ADC) / not-borrow (SBC)
// -----------------------------------------------------------------------------
module bcd_adjust (
  input  logic [7:0] bin_sum,
  input  logic       half_carry,
  input  logic       carry_in,
  input  logic       is_sub,
  output logic [7:0] adj_out,
  output logic       carry_out
);

  logic       lo_fix;
  logic       hi_fix;
  logic [7:0] lo_amt;
  logic [7:0] hi_amt;

  always_comb begin
    lo_fix    = 1'b0;
    hi_fix    = 1'b0;
    lo_amt    = 8'h00;
    hi_amt    = 8'h00;
    adj_out   = bin_sum;
    carry_out = carry_in;

    if (is_sub) begin
      // Subtraction: a borrow out of a nibble means that nibble wrapped
      // through 16 instead of 10, so take 6 back off it.
      lo_fix    = ~half_carry;
      hi_fix    = ~carry_in;
      lo_amt    = lo_fix ? 8'h06 : 8'h00;
      hi_amt    = hi_fix ? 8'h60 : 8'h00;
      adj_out   = bin_sum - lo_amt - hi_amt;
      carry_out = carry_in;
    end else begin
      // Addition: a nibble above 9 or a nibble carry needs +6. The high
      // digit test uses the unadjusted sum so a low fix that ripples into
      // the high nibble is already accounted for by the > 0x99 check.
      lo_fix    = half_carry || (bin_sum[3:0] > 4'd9);
      hi_fix    = carry_in || (bin_sum > 8'h99);
      lo_amt    = lo_fix ? 8'h06 : 8'h00;
      hi_amt    = hi_fix ? 8'h60 : 8'h00;
      adj_out   = bin_sum + lo_amt + hi_amt;
      carry_out = hi_fix;
    end
  end

endmodule

// File: rtl/alu_flag_unit.sv
// -----------------------------------------------------------------------------
// alu_flag_unit
// Multi-cycle 8-bit ALU that computes a result plus N/V/Z/C flags and hands
// them to the processor status register through a request/acknowledge pair.
//
// Ports:
//   fclk               (in)      clock, rising edge
//   rst                (in)      synchronous active-high reset
//   start              (in)      operation request, sampled only in IDLE
//   alu_op             (in, 4)   operation code (alu_op_t)
//   a_in, b_in         (in, 8)   operands
//   c_carry, d_decimal, v_in (in) current C, D, V flags
//   busy               (out)     high whenever the FSM is not IDLE
//   result_out         (out, 8)  registered result
//   result_valid       (out)     one-cycle pulse after the status register acks
//   psr_update_request (out)     flags are ready for the status register
//   ack_update_request (in)      status register acknowledge
//   n_result, v_result, z_result, c_result (out) registered flags
//   state_dbg          (out, 2)  current FSM state (alu_state_t encoding)
//
// Handshake: psr_update_request is high for every cycle the FSM sits in REQ;
// result_out and the flags are frozen for that whole time. The first rising
// edge that samples ack_update_request=1 while in REQ completes the
// transfer: the FSM returns to IDLE and result_valid pulses for one cycle.
// ack outside REQ and start outside IDLE have no effect.
//
// Timing from the start edge: EXEC (cycle 1) -> REQ (cycle 2) for binary
// ops; EXEC -> DADJ -> REQ (cycle 3) for ADC/SBC with D=1.
// -----------------------------------------------------------------------------
module alu_flag_unit
  import core_pkg::*;
(
  input  logic       fclk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] alu_op,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic       c_carry,
  input  logic       d_decimal,
  input  logic       v_in,
  output logic       busy,
  output logic [7:0] result_out,
  output logic       result_valid,
  output logic       psr_update_request,
  input  logic       ack_update_request,
  output logic       n_result,
  output logic       v_result,
  output logic       z_result,
  output logic       c_result,
  output logic [1:0] state_dbg
);

  // ---------------------------------------------------------------------------
  // Captured operation
  // ---------------------------------------------------------------------------
  alu_state_t state;
  alu_state_t state_nxt;

  alu_op_t    op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       c_q;
  logic       d_q;
  logic       v_q;
  logic       hc_q;

  alu_out_t   exec_res;

  logic [7:0] adj_byte;
  logic       adj_carry;

  // ---------------------------------------------------------------------------
  // Binary execute: purely a function of the captured operands
  // ---------------------------------------------------------------------------
  logic [7:0] b_eff;
  logic       add_cin;
  logic [8:0] sum9;
  logic [4:0] low5;
  logic       add_ovf;
  logic [7:0] flag_src;

  always_comb begin
    // ADC adds B; SBC and CMP add ~B (two's complement with carry-in).
    b_eff   = (op_q == OP_ADC) ? b_q : ~b_q;
    // CMP is a plain A-B and ignores the incoming carry.
    add_cin = (op_q == OP_CMP) ? 1'b1 : c_q;
    sum9    = {1'b0, a_q} + {1'b0, b_eff} + {8'b0, add_cin};
    low5    = {1'b0, a_q[3:0]} + {1'b0, b_eff[3:0]} + {4'b0, add_cin};
    // Signed overflow: operands agree in sign, result disagrees.
    add_ovf = (a_q[7] == b_eff[7]) && (sum9[7] != a_q[7]);

    exec_res        = '0;
    exec_res.result = a_q;
    exec_res.c      = c_q;
    exec_res.v      = v_q;
    exec_res.hc     = 1'b0;

    unique case (op_q)
      OP_ADC, OP_SBC: begin
        exec_res.result = sum9[7:0];
        exec_res.c      = sum9[8];
        exec_res.v      = add_ovf;
        exec_res.hc     = low5[4];
      end
      OP_CMP: begin
        exec_res.result = a_q;
        exec_res.c      = sum9[8];
      end
      OP_AND: exec_res.result = a_q & b_q;
      OP_ORA: exec_res.result = a_q | b_q;
      OP_EOR: exec_res.result = a_q ^ b_q;
      OP_ASL: begin
        exec_res.result = {a_q[6:0], 1'b0};
        exec_res.c      = a_q[7];
      end
      OP_LSR: begin
        exec_res.result = {1'b0, a_q[7:1]};
        exec_res.c      = a_q[0];
      end
      OP_ROL: begin
        exec_res.result = {a_q[6:0], c_q};
        exec_res.c      = a_q[7];
      end
      OP_ROR: begin
        exec_res.result = {c_q, a_q[7:1]};
        exec_res.c      = a_q[0];
      end
      OP_INC: exec_res.result = a_q + 8'h01;
      OP_DEC: exec_res.result = a_q - 8'h01;
      default: exec_res.result = a_q;
    endcase

    // CMP reports N/Z of the difference while passing A through as result.
    flag_src   = (op_q == OP_CMP) ? sum9[7:0] : exec_res.result;
    exec_res.n = flag_src[7];
    exec_res.z = (flag_src == 8'h00);
  end

  // ---------------------------------------------------------------------------
  // Decimal correction works on the binary result already in result_out
  // and on the binary carry already in c_result.
  // ---------------------------------------------------------------------------
  bcd_adjust u_bcd_adjust (
    .bin_sum    (result_out),
    .half_carry (hc_q),
    .carry_in   (c_result),
    .is_sub     (op_q == OP_SBC),
    .adj_out    (adj_byte),
    .carry_out  (adj_carry)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge fclk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = (is_bcd_op(op_q) && d_q) ? ST_DADJ : ST_REQ;
      ST_DADJ: state_nxt = ST_REQ;
      ST_REQ:  if (ack_update_request) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    busy               = (state != ST_IDLE);
    psr_update_request = (state == ST_REQ);
    state_dbg          = state;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge fclk) begin
    if (rst) begin
      op_q         <= OP_ADC;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      c_q          <= 1'b0;
      d_q          <= 1'b0;
      v_q          <= 1'b0;
      hc_q         <= 1'b0;
      result_out   <= 8'h00;
      n_result     <= 1'b0;
      v_result     <= 1'b0;
      z_result     <= 1'b0;
      c_result     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= (state == ST_REQ) && ack_update_request;

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= alu_op_t'(alu_op);
            a_q  <= a_in;
            b_q  <= b_in;
            c_q  <= c_carry;
            d_q  <= d_decimal;
            v_q  <= v_in;
          end
        end
        ST_EXEC: begin
          result_out <= exec_res.result;
          n_result   <= exec_res.n;
          v_result   <= exec_res.v;
          z_result   <= exec_res.z;
          c_result   <= exec_res.c;
          hc_q       <= exec_res.hc;
        end
        ST_DADJ: begin
          // V stays at the binary value registered in EXEC.
          result_out <= adj_byte;
          c_result   <= adj_carry;
          n_result   <= adj_byte[7];
          z_result   <= (adj_byte == 8'h00);
        end
        default: begin
          // REQ: everything held for the status register.
        end
      endcase
    end
  end

endmodule

// File: doc/alu_flag_unit.md
ALU_FLAG_UNIT -- requirements
Module: alu_flag_unit

Interface
REQ-001 The module SHALL have the port fclk, an input, 1 bit wide: the single clock; all state updates occur on its rising edge.
REQ-002 The module SHALL have the port rst, an input, 1 bit wide: reset, synchronous and active-high.
REQ-003 The module SHALL have the port start, an input, 1 bit wide: operation request, sampled only in IDLE.
REQ-004 The module SHALL have the port alu_op, an input, 4 bits wide: operation code (alu_op_t).
REQ-005 The module SHALL have the ports a_in and b_in, inputs, 8 bits wide each: operands.
REQ-006 The module SHALL have the ports c_carry, d_decimal and v_in, inputs, 1 bit wide each: current C, D and V flags.
REQ-007 The module SHALL have the port busy, an output, 1 bit wide: high in every state except IDLE.
REQ-008 The module SHALL have the port result_out, an output, 8 bits wide: registered result, held until the next operation completes.
REQ-009 The module SHALL have the port result_valid, an output, 1 bit wide: one-cycle completion pulse.
REQ-010 The module SHALL have the port psr_update_request, an output, 1 bit wide: flag-update request to the status register.
REQ-011 The module SHALL have the port ack_update_request, an input, 1 bit wide: status-register acknowledge.
REQ-012 The module SHALL have the ports n_result, v_result, z_result and c_result, outputs, 1 bit wide each: registered flags.

Function
REQ-013 The state machine SHALL implement the states IDLE, EXEC, DADJ and REQ.
REQ-014 When start=1 in IDLE, the module SHALL capture alu_op, a_in, b_in, c_carry, d_decimal and v_in at that edge and go to EXEC.
REQ-015 Inputs SHALL be ignored outside IDLE, and start while busy SHALL be dropped.
REQ-016 EXEC SHALL register the binary result and flags, then go to DADJ if the op is ADC/SBC with D=1, and to REQ otherwise.
REQ-017 DADJ SHALL apply the BCD correction for one cycle and then go to REQ.
REQ-018 Binary ops SHALL give psr_update_request=1 in the 2nd cycle after the start edge; decimal ops SHALL give it in the 3rd.
REQ-019 In REQ, psr_update_request SHALL be 1 and all flags and result_out SHALL be held stable until ack_update_request=1 is sampled.
REQ-020 When ack is sampled high, the module SHALL return to IDLE and pulse result_valid=1 for exactly one cycle.
REQ-021 ack_update_request SHALL be ignored outside REQ.
REQ-022 ADC SHALL compute A+B+C; V SHALL be signed overflow of the binary sum; C SHALL be carry out of bit 7.
REQ-023 SBC SHALL compute A+~B+C; C=1 SHALL mean no borrow.
REQ-024 In decimal mode, result, C, N and Z SHALL come from the adjusted value, and V SHALL come from the binary intermediate.
REQ-025 CMP SHALL compute A-B: N, Z and C per subtraction, v_result=v_in, result_out=A.
REQ-026 AND, ORA and EOR SHALL update N and Z only, with c_result=c_carry and v_result=v_in.
REQ-027 ASL, LSR, ROL and ROR SHALL operate on A; C SHALL take the shifted-out bit; ROL/ROR SHALL shift in c_carry; V SHALL pass through.
REQ-028 INC and DEC SHALL operate on A modulo 256 (0xFF+1=0x00, 0x00-1=0xFF), with C and V passed through.
REQ-029 For every op, N SHALL be result bit 7 and Z SHALL be (result==0).
REQ-030 Undefined alu_op codes SHALL pass A through, update N and Z, and pass C and V through.

Reset
REQ-031 When rst=1 at an edge, the module SHALL go to IDLE and clear busy, result_valid, psr_update_request, result_out, n_result, v_result, z_result and c_result to 0.
REQ-032 rst SHALL have priority over start and ack, and reset mid-operation SHALL abort with no result_valid pulse.

Structure
REQ-033 alu_op_t and the state enum SHALL live in the shared package core_pkg.
REQ-034 The decimal correction SHALL be the combinational sub-module bcd_adjust (inputs: binary sum, half-carry, carry, is_sub; outputs: adjusted byte, carry).

Verification
REQ-035 The bench SHALL cover: ADC with A=0x50, B=0x50, C=0, D=0 -> result 0xA0, N=1, V=1, Z=0, C=0, with the request in cycle 2.
REQ-036 The bench SHALL cover: ADC with A=0x58, B=0x46, C=1, D=1 -> result 0x05, C=1, N=0, Z=0, with the request in cycle 3.
REQ-037 The bench SHALL cover: SBC with A=0x46, B=0x12, C=1, D=1 -> result 0x34, C=1; and CMP with A=0x10, B=0x10, v_in=1 -> Z=1, C=1, N=0, V=1.
REQ-038 The bench SHALL cover: ack held low for 5 cycles in REQ -> request and flags stay constant, start pulses are dropped, and exactly one result_valid follows the ack.
REQ-039 The bench SHALL cover: rst asserted in DADJ -> IDLE on the next edge with all outputs 0 and no result_valid; and INC with A=0xFF -> result 0x00, Z=1, C=c_carry.
